or32_response_checker: RTL and testbench
========================================

# or32_response_checker

Synthesizable response checker for the 32-bit OR datapath. It reads each result/flag vector the OR unit produces for a given operand pair, computes the expected value, and compares the two. It keeps pass/error counts and captures the first failing vector for debug. It is the consuming end of the stimulus interface: a stimulus driver or test sequencer presents vectors, and this block accepts, checks and reports them.

## Interface
Parameters:
- CNT_W, 16, width of the checked and error counters (saturating)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; clears counters and capture, enters RUN
- stop  input  1  one-cycle pulse; no more vectors, drain and finish
- in_valid  input  1  vector present on a/b/result/flags
- in_ready  output  1  checker accepts a vector this cycle
- a, b  input  32 each  operands driven into the OR unit
- result  input  32  OR unit result
- zero, overflow, carryOut, negative  input  1 each  OR unit flags
- mismatch  output  1  one-cycle pulse per failing vector
- checked_count  output  CNT_W  vectors checked
- error_count  output  CNT_W  vectors failed
- first_err_a, first_err_b, first_err_result  output  32 each  capture of the first failing vector
- busy  output  1  state is RUN or DRAIN
- done  output  1  state is DONE
- pass  output  1  done, error_count==0 and checked_count!=0

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -start-> RUN.
  - RUN -stop-> DRAIN if a vector is pending in the stage register; otherwise RUN -stop-> DONE.
  - DRAIN -> DONE after the pending vector is checked.
  - DONE -start-> RUN.
- start is ignored in RUN and DRAIN. stop is ignored in IDLE and DONE. If start and stop arrive in the same cycle in IDLE or DONE, start wins.
- in_ready = (state==RUN) and stop not asserted in the previous cycle. It is a registered-state decode.
- A vector is accepted when in_valid && in_ready at a rising edge. a, b, result and the four flags go into a single stage register, plus a stage_valid bit.
- Expected values are computed from the staged operands:
  - exp_result = a|b
  - exp_zero = (exp_result==0)
  - exp_negative = exp_result[31]
  - exp_overflow = 0
  - exp_carryOut = 0
- Fail if any of the five fields differs from its expected value.
- On each checked vector, checked_count increments. On a fail, error_count increments. Both counters saturate at all-ones and never wrap.
- On the first fail after start, the first_err_* registers capture the staged a, b and result. Later fails do not overwrite them.
- start clears both counters, all first_err_* registers, the capture-taken flag and stage_valid.
- If stop and an accepted vector fall in the same cycle, the vector is accepted and checked. The state then goes to DRAIN.

## Timing
- Reset (reset_n low, asynchronous) sets:
  - state=IDLE
  - in_ready=0, mismatch=0
  - all counters and first_err_* = 0
  - busy=0, done=0, pass=0
  - stage_valid=0
- Latency: for a vector accepted at edge k, checked_count, error_count and first_err_* update at edge k+1, and mismatch is high from edge k+1 to edge k+2.
- Throughput: one vector per cycle while in RUN; there are no bubbles.
- in_ready drops in the cycle after stop is sampled.
- DONE is reached exactly one edge after the last staged vector is checked, or at the stop edge if nothing is pending.
- If reset_n is asserted mid-run, the pending vector is discarded and no mismatch is emitted.
- The done and pass outputs are registered and stay stable until the next start or reset.

## Test plan
- Reset, start, one vector a=0, b=0, result=0, zero=1, other flags 0, then stop. Required: checked=1, errors=0, pass=1, mismatch never asserted.
- Vector a=0x0000004F, b=0x0000001B, result=0x0000005F, all flags 0. Required: passes. Then the same vector with result=0x0000005B. Required: mismatch pulses one cycle after acceptance, error_count=1, and first_err_result=0x0000005B.
- Vector a=0xD5000000, b=0x25000000, result=0xF5000000, negative=0. Required: fails on the flag; the same vector with negative=1 passes.
- Back-to-back stream of 3 vectors, the 2nd and 3rd bad, with stop asserted alongside the 3rd. Required: all three accepted, DRAIN for one cycle then DONE, errors=2, first_err holds the 2nd vector, and pass=0.
- Preload the counters to CNT_W=4 equivalent by streaming 17 failing vectors. Required: error_count and checked_count hold at 0xF and do not wrap.
- Drop reset_n while a vector is staged. Required: all outputs go to zero immediately with no mismatch pulse. After reset_n rises, the checker stays in IDLE until start.

Source files
------------

// File: rtl/or32_response_checker.sv
// or32_response_checker
//
// Consumes result/flag vectors from the 32-bit OR unit, recomputes the
// expected result and flags from the operands, and reports pass/fail.
// Saturating checked/error counters, plus a capture of the first failing
// vector since the last start.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, stop         one-cycle control pulses
//   in_valid/in_ready   vector handshake (accept when both high at an edge)
//   a, b                operands driven into the OR unit
//   result, zero, overflow, carryOut, negative   OR unit outputs under test
//   mismatch            one-cycle pulse per failing vector
//   checked_count       vectors checked (saturating)
//   error_count         vectors failed (saturating)
//   first_err_*         operands/result of the first failing vector
//   busy, done, pass    status (registered)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | accepting one vector per cycle
// DRAIN | stop seen with a vector still staged; check it, then finish
// DONE  | finished; counters, capture and pass held until next start

module or32_response_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [31:0]      result,
  input  logic             zero,
  input  logic             overflow,
  input  logic             carryOut,
  input  logic             negative,
  output logic             mismatch,
  output logic [CNT_W-1:0] checked_count,
  output logic [CNT_W-1:0] error_count,
  output logic [31:0]      first_err_a,
  output logic [31:0]      first_err_b,
  output logic [31:0]      first_err_result,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic        stop_q;
  logic        stage_valid;
  logic [31:0] st_a, st_b, st_res;
  logic        st_z, st_v, st_c, st_n;
  logic        captured;

  logic             accept, start_clr, fail, err_fire;
  logic [31:0]      exp_res;
  logic [CNT_W-1:0] chk_nxt, err_nxt;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign in_ready  = (state == RUN) && !stop_q;
  assign accept    = in_valid && in_ready;
  assign start_clr = start && ((state == IDLE) || (state == DONE));

  // OR never overflows or carries; only zero and negative depend on data.
  assign exp_res  = st_a | st_b;
  assign fail     = (st_res != exp_res) || (st_z != (exp_res == 32'd0)) ||
                    (st_n != exp_res[31]) || st_v || st_c;
  assign err_fire = stage_valid && fail;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      // A vector accepted alongside stop is still staged after this edge.
      RUN:   if (stop) state_nxt = accept ? DRAIN : DONE;
      DRAIN: state_nxt = DONE;
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    chk_nxt = checked_count;
    err_nxt = error_count;
    if (start_clr) begin
      chk_nxt = '0;
      err_nxt = '0;
    end else begin
      if (stage_valid && (checked_count != CNT_MAX))
        chk_nxt = checked_count + CNT_W'(1);
      if (err_fire && (error_count != CNT_MAX))
        err_nxt = error_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      stop_q           <= 1'b0;
      stage_valid      <= 1'b0;
      st_a             <= '0;
      st_b             <= '0;
      st_res           <= '0;
      st_z             <= 1'b0;
      st_v             <= 1'b0;
      st_c             <= 1'b0;
      st_n             <= 1'b0;
      captured         <= 1'b0;
      mismatch         <= 1'b0;
      checked_count    <= '0;
      error_count      <= '0;
      first_err_a      <= '0;
      first_err_b      <= '0;
      first_err_result <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state       <= state_nxt;
      stop_q      <= stop && (state == RUN);
      stage_valid <= accept;
      if (accept) begin
        st_a   <= a;
        st_b   <= b;
        st_res <= result;
        st_z   <= zero;
        st_v   <= overflow;
        st_c   <= carryOut;
        st_n   <= negative;
      end
      checked_count <= chk_nxt;
      error_count   <= err_nxt;
      mismatch      <= err_fire;
      if (start_clr) begin
        captured         <= 1'b0;
        first_err_a      <= '0;
        first_err_b      <= '0;
        first_err_result <= '0;
      end else if (err_fire && !captured) begin
        captured         <= 1'b1;
        first_err_a      <= st_a;
        first_err_b      <= st_b;
        first_err_result <= st_res;
      end
      // Status is derived from next-state values so it lines up with state.
      busy <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done <= (state_nxt == DONE);
      pass <= (state_nxt == DONE) && (err_nxt == '0) && (chk_nxt != '0);
    end
  end

endmodule

// File: tb/tb_or32_response_checker.sv
// Testbench for or32_response_checker. Directed vectors with hand-computed
// expected pass/fail are pushed into a queue by the stimulus; a monitor
// pops one entry per accepted vector and compares the mismatch pulse two
// sampling points later. Counters, capture and status are checked directly.

module tb_or32_response_checker;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             start, stop, in_valid, in_ready;
  logic [31:0]      a, b, result;
  logic             zero, overflow, carryOut, negative;
  logic             mismatch;
  logic [CNT_W-1:0] checked_count, error_count;
  logic [31:0]      first_err_a, first_err_b, first_err_result;
  logic             busy, done, pass;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   exp_q[$];
  logic [1:0] pipe;

  or32_response_checker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .result(result),
    .zero(zero), .overflow(overflow), .carryOut(carryOut), .negative(negative),
    .mismatch(mismatch), .checked_count(checked_count), .error_count(error_count),
    .first_err_a(first_err_a), .first_err_b(first_err_b),
    .first_err_result(first_err_result), .busy(busy), .done(done), .pass(pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [31:0] va, vb, vr,
                           input logic vz, vv, vc, vn, input bit exp_fail);
    in_valid = 1'b1;
    a = va; b = vb; result = vr;
    zero = vz; overflow = vv; carryOut = vc; negative = vn;
    exp_q.push_back(exp_fail);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Monitor: handshake seen before edge k -> mismatch sampled after edge k+1.
  initial begin
    pipe = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pipe = 2'b00;
        exp_q.delete();
      end else begin
        if (pipe[1]) begin
          if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
          else chk("mismatch", {31'd0, mismatch}, {31'd0, exp_q.pop_front()});
        end else begin
          chk("mismatch_idle", {31'd0, mismatch}, 32'd0);
        end
        pipe = {pipe[0], in_valid && in_ready};
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; result = '0;
    zero = 1'b0; overflow = 1'b0; carryOut = 1'b0; negative = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst_checked", {28'd0, checked_count}, 32'd0);
    chk("rst_errors", {28'd0, error_count}, 32'd0);
    chk("rst_first_err_a", first_err_a, 32'd0);
    chk("rst_status", {29'd0, busy, done, pass}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single all-zero vector passes
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    drive_vec(32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    pulse_stop();
    chk("t1_checked", {28'd0, checked_count}, 32'd1);
    chk("t1_errors", {28'd0, error_count}, 32'd0);
    chk("t1_done_pass", {29'd0, busy, done, pass}, 32'b011);
    chk("t1_in_ready_off", {31'd0, in_ready}, 32'd0);

    // 2: 0x4F|0x1B=0x5F good, then result 0x5B bad
    pulse_start();
    chk("t2_cleared", {28'd0, checked_count}, 32'd0);
    drive_vec(32'h4F, 32'h1B, 32'h5F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_vec(32'h4F, 32'h1B, 32'h5B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("t2_errors", {28'd0, error_count}, 32'd1);
    chk("t2_checked", {28'd0, checked_count}, 32'd2);
    chk("t2_first_res", first_err_result, 32'h5B);
    chk("t2_first_a", first_err_a, 32'h4F);
    chk("t2_first_b", first_err_b, 32'h1B);
    pulse_stop();
    chk("t2_pass", {31'd0, pass}, 32'd0);

    // 3: 0xD5000000|0x25000000=0xF5000000, negative flag must be 1
    pulse_start();
    chk("t3_capture_clr", first_err_result, 32'd0);
    drive_vec(32'hD500_0000, 32'h2500_0000, 32'hF500_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_vec(32'hD500_0000, 32'h2500_0000, 32'hF500_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_stop();
    chk("t3_errors", {28'd0, error_count}, 32'd1);
    chk("t3_checked", {28'd0, checked_count}, 32'd2);
    chk("t3_first_res", first_err_result, 32'hF500_0000);
    chk("t3_done", {31'd0, done}, 32'd1);

    // 4: back-to-back, 2nd and 3rd bad, stop alongside 3rd
    pulse_start();
    drive_vec(32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_vec(32'h1, 32'h2, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b1;
    drive_vec(32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b0;
    chk("t4_drain", {29'd0, busy, done, in_ready}, 32'b100);
    tick();
    chk("t4_done", {29'd0, busy, done, pass}, 32'b010);
    chk("t4_checked", {28'd0, checked_count}, 32'd3);
    chk("t4_errors", {28'd0, error_count}, 32'd2);
    chk("t4_first_res", first_err_result, 32'h4);
    chk("t4_first_a", first_err_a, 32'h1);

    // 5: 17 failing vectors saturate 4-bit counters
    pulse_start();
    for (int i = 0; i < 17; i++)
      drive_vec(32'(i + 1), 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("t5_checked_sat", {28'd0, checked_count}, 32'hF);
    chk("t5_errors_sat", {28'd0, error_count}, 32'hF);
    chk("t5_first_a", first_err_a, 32'h1);
    pulse_stop();
    chk("t5_pass", {31'd0, pass}, 32'd0);

    // 6: reset while a failing vector is staged
    pulse_start();
    drive_vec(32'h10, 32'h01, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t6_mismatch", {31'd0, mismatch}, 32'd0);
    chk("t6_counts", {24'd0, checked_count, error_count}, 32'd0);
    chk("t6_status", {28'd0, busy, done, pass, in_ready}, 32'd0);
    chk("t6_first_a", first_err_a, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_idle", {28'd0, busy, done, pass, in_ready}, 32'd0);
    chk("t6_counts_idle", {24'd0, checked_count, error_count}, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
